// File: rtl/axi_write_master.sv
// -----------------------------------------------------------------------------
// axi_write_master
//
// Downstream stage of the memory writer. Accepts one burst command (start
// pulse plus AXI attributes) and a beat stream of data/strobe, and drives an
// AXI4 master write port (AW/W/B). One burst is outstanding at a time.
//
// Optional build macro: AXI_WR_TIMEOUT_EN
//   When defined, the RESP state gives up after TIMEOUT_CYCLES cycles without
//   bvalid, flags resp_err, pulses done, and pulses the extra 'timeout' output.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start_write                one-cycle command pulse (honoured only in IDLE)
//   write_id/addr/len/size/burst  burst attributes, latched on start_write
//   write_data, write_strb     beat payload, passed straight through to W
//   wr_data_valid / wr_data_ready  beat handshake with the writer
//   busy                       high in every state except IDLE
//   done                       one-cycle pulse on burst completion
//   resp_err                   sticky error status of the last burst
//   aw*, w*, b*                AXI4 write address / data / response channels
//   timeout                    (AXI_WR_TIMEOUT_EN only) pulses with done on timeout
// -----------------------------------------------------------------------------
module axi_write_master #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int ID_WIDTH       = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                    clk,
   input  logic                    rst_n,
   // command and beat stream from the writer
   input  logic                    start_write,
   input  logic [ID_WIDTH-1:0]     write_id,
   input  logic [ADDR_WIDTH-1:0]   write_addr,
   input  logic [7:0]              write_len,
   input  logic [2:0]              write_size,
   input  logic [1:0]              write_burst,
   input  logic [DATA_WIDTH-1:0]   write_data,
   input  logic [DATA_WIDTH/8-1:0] write_strb,
   input  logic                    wr_data_valid,
   output logic                    wr_data_ready,
   // status back to the writer
   output logic                    busy,
   output logic                    done,
   output logic                    resp_err,
`ifdef AXI_WR_TIMEOUT_EN
   output logic                    timeout,
`endif
   // AXI4 write address channel
   output logic [ID_WIDTH-1:0]     awid,
   output logic [ADDR_WIDTH-1:0]   awaddr,
   output logic [7:0]              awlen,
   output logic [2:0]              awsize,
   output logic [1:0]              awburst,
   output logic                    awvalid,
   input  logic                    awready,
   // AXI4 write data channel
   output logic [DATA_WIDTH-1:0]   wdata,
   output logic [DATA_WIDTH/8-1:0] wstrb,
   output logic                    wlast,
   output logic                    wvalid,
   input  logic                    wready,
   // AXI4 write response channel
   input  logic [ID_WIDTH-1:0]     bid,
   input  logic [1:0]              bresp,
   input  logic                    bvalid,
   output logic                    bready
);

   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   // Elaboration-time sanity checks on the configuration.
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("axi_write_master: TIMEOUT_CYCLES must be at least 1");
   end
   if (DATA_WIDTH % 8 != 0) begin : g_bad_width
      $error("axi_write_master: DATA_WIDTH must be a multiple of 8");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2,
      RESP = 2'd3
   } state_t;

   state_t     state;
   logic [7:0] beat_cnt;   // beats accepted so far in the current burst
   logic       err_q;      // registered error status of the last burst
   logic       w_hs;       // W beat transferred this cycle
   logic       resp_hit;   // RESP finishes this cycle (bvalid or timeout)
   logic       err_now;    // error status of the response finishing now

   // ---------------------------------------------------------------------------
   // Channel outputs decoded from the state register. W is a zero-latency
   // pass-through of the beat stream, gated so nothing leaks outside DATA.
   // ---------------------------------------------------------------------------
   assign busy          = (state != IDLE);
   assign awvalid       = (state == ADDR);
   assign bready        = (state == RESP);
   assign wvalid        = (state == DATA) && wr_data_valid;
   assign wr_data_ready = (state == DATA) && wready;
   assign wdata         = (state == DATA) ? write_data : '0;
   assign wstrb         = (state == DATA) ? write_strb : {STRB_WIDTH{1'b0}};
   assign wlast         = (state == DATA) && (beat_cnt == awlen);
   assign w_hs          = wvalid && wready;

`ifdef AXI_WR_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic [TW-1:0] resp_timer;   // cycles spent in RESP without bvalid
   logic          to_hit;

   assign to_hit   = (state == RESP) && (resp_timer == TO_LAST);
   // A real response wins over a timeout landing in the same cycle.
   assign resp_hit = bready && (bvalid || to_hit);
   assign err_now  = bvalid ? (bresp[1] | (bid != awid)) : 1'b1;
   assign timeout  = bready && !bvalid && to_hit;

   // Held at zero outside RESP, so it restarts on every entry to RESP.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_timer <= '0;
      end else if (state != RESP) begin
         resp_timer <= '0;
      end else if (!to_hit) begin
         resp_timer <= resp_timer + 1'b1;
      end
   end
`else
   assign resp_hit = bready && bvalid;
   // SLVERR/DECERR have bresp[1] set; a foreign ID is treated as an error too.
   assign err_now  = bresp[1] | (bid != awid);
`endif

   // done and the fresh error status are visible in the completing cycle, so
   // done and busy drop together and resp_err is already valid alongside done.
   assign done     = resp_hit;
   assign resp_err = err_q | (resp_hit & err_now);

   // ---------------------------------------------------------------------------
   // Burst state machine. The AW payload registers double as the latched
   // command, so awlen/awid also serve the wlast and ID comparisons.
   // ---------------------------------------------------------------------------
   // NOTE: every register below uses non-blocking assignment so all of them
   // update from the same pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         awid     <= '0;
         awaddr   <= '0;
         awlen    <= '0;
         awsize   <= '0;
         awburst  <= '0;
         beat_cnt <= '0;
         err_q    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start_write) begin
                  awid    <= write_id;
                  awaddr  <= write_addr;
                  awlen   <= write_len;
                  awsize  <= write_size;
                  awburst <= write_burst;
                  err_q   <= 1'b0;
                  state   <= ADDR;
               end
            end
            ADDR: begin
               if (awready) begin
                  beat_cnt <= '0;
                  state    <= DATA;
               end
            end
            DATA: begin
               if (w_hs) begin
                  beat_cnt <= beat_cnt + 8'd1;
                  if (wlast) begin
                     state <= RESP;
                  end
               end
            end
            RESP: begin
               if (resp_hit) begin
                  err_q <= err_now;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/axi_write_master.md
Name: axi_write_master

Overview:
- Downstream stage of the memory writer: accepts one burst command (start pulse plus AXI attributes) and a beat stream of data and strobe.
- Drives an AXI4 master write port (AW/W/B channels) toward the interconnect or DRAM controller.
- Reports per-burst completion and error status back to the writer.
- One burst outstanding at a time; no reordering.

Parameters:
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data bus width; strobe width is DATA_WIDTH/8
- ID_WIDTH, 4, AXI ID width
- TIMEOUT_CYCLES, 1024, B-response timeout; used only with the optional feature

Ports:
- clk  in  1  single clock
- rst_n  in  1  asynchronous active-low reset
- start_write  in  1  one-cycle command pulse
- write_id  in  ID_WIDTH  burst ID
- write_addr  in  ADDR_WIDTH  start address
- write_len  in  8  beats minus 1
- write_size  in  3  log2 bytes per beat
- write_burst  in  2  burst type
- write_data  in  DATA_WIDTH  beat data
- write_strb  in  DATA_WIDTH/8  beat strobes
- wr_data_valid  in  1  beat present
- wr_data_ready  out  1  beat consumed
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse, burst complete
- resp_err  out  1  sticky error for the last burst
- awid/awaddr/awlen/awsize/awburst  out  ID_WIDTH/ADDR_WIDTH/8/3/2  AW payload
- awvalid  out  1; awready  in  1
- wdata/wstrb  out  DATA_WIDTH/DATA_WIDTH/8
- wlast  out  1; wvalid  out  1; wready  in  1
- bid  in  ID_WIDTH; bresp  in  2; bvalid  in  1; bready  out  1

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: state IDLE; all outputs 0, including the AW payload registers and the beat counter.
- State machine: IDLE -> ADDR -> DATA -> RESP -> IDLE.
- IDLE:
  - start_write=1 latches id/addr/len/size/burst into registers and moves to ADDR next cycle.
  - start_write is ignored in any state other than IDLE (no queueing).
- ADDR:
  - awvalid=1; AW payload comes from registers and is stable while awvalid=1.
  - On awvalid&&awready: drop awvalid, go to DATA.
- DATA:
  - wvalid = wr_data_valid.
  - wr_data_ready = wready.
  - wdata/wstrb = write_data/write_strb (combinational pass-through, zero latency).
  - 8-bit beat counter cleared on entry; increments on each wvalid&&wready.
  - wlast=1 exactly when counter==latched len; len=0 gives a single beat with wlast.
  - Handshake on the wlast beat -> RESP.
  - wvalid is low and wr_data_ready is low outside DATA.
- RESP:
  - bready=1.
  - On bvalid: resp_err = bresp[1] | (bid != latched id).
  - done=1 for exactly that cycle; go to IDLE.
- busy=1 in every state except IDLE.
- resp_err clears when a new start_write is accepted.
- done and busy deassert together; a start_write in the done cycle is ignored. The next command is accepted the following cycle.
- Stalls: awready low or wready low for any number of cycles holds state and counter. No beat is dropped or duplicated.
- A bvalid arriving before the RESP state is not accepted (bready=0).
- Reset asserted mid-burst: immediate return to IDLE with all valids low. The partial burst is abandoned; no done pulse.

Optional Feature:
- Macro: AXI_WR_TIMEOUT_EN.
- When defined:
  - A counter runs in RESP and resets on entry to RESP.
  - If TIMEOUT_CYCLES elapse without bvalid: assert resp_err=1 and done=1, then go to IDLE.
  - An extra output timeout (1 bit, reset 0) pulses alongside done.
- When undefined: RESP waits indefinitely, and the timeout port and counter do not exist.

Test Plan:
- Single beat: start with id=3, addr=0x1000, len=0, size=2, burst=1; awready=1, wready=1, bvalid=1 with bresp=0 after 1 cycle -> one AW with awlen=0; one W beat with wlast=1; done pulses once; resp_err=0.
- Burst of 16 (len=15) with wready toggling every other cycle -> exactly 16 W handshakes; wlast only on the 16th; data order preserved.
- awready held low 5 cycles -> AW payload stable throughout; no W beat accepted before the AW handshake.
- Error responses:
  - bresp=2'b10 -> resp_err=1 after done.
  - Next burst with bresp=0 -> resp_err=0.
  - bid=5 vs id=3 -> resp_err=1.
- start_write pulsed during DATA and in the done cycle -> ignored; no second AW is issued.
- rst_n low during beat 4 of 8 -> all valids 0 immediately; busy=0; a fresh command afterwards completes normally. With AXI_WR_TIMEOUT_EN and TIMEOUT_CYCLES=8, bvalid never asserted -> done, resp_err and timeout all 1 on the 8th RESP cycle.
